// File: rtl/fu_pkg.sv
// Shared constants for the execution pool: FU type codes,
// instruction field positions and unit state encoding.
package fu_pkg;

  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_LSU = 2'd1;
  localparam logic [1:0] FU_MUL = 2'd2;
  localparam logic [1:0] FU_DIV = 2'd3;

  localparam int OP_HI   = 7;
  localparam int OP_LO   = 6;
  localparam int SRC0_HI = 5;
  localparam int SRC0_LO = 4;
  localparam int SRC1_HI = 3;
  localparam int SRC1_LO = 2;
  localparam int DEST_HI = 1;
  localparam int DEST_LO = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [1:0] instr_dest(
    input logic [7:0] instr
  );
    return instr[DEST_HI:DEST_LO];
  endfunction

endpackage

// File: rtl/fu_unit.sv
// Single multi-cycle functional unit: IDLE -> EXEC (LAT cycles) -> DONE.
// Ports: start/slot_in/dest_in load work, grant retires it; busy/done/slot/dest report status.
module fu_unit
  import fu_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       start,
  input  logic [1:0] slot_in,
  input  logic [1:0] dest_in,
  input  logic       grant,
  output logic       busy,
  output logic       done,
  output logic [1:0] slot,
  output logic [1:0] dest
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      slot  <= '0;
      dest  <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_EXEC;
            cnt   <= CNT_W'(LAT);
            slot  <= slot_in;
            dest  <= dest_in;
          end
        end
        ST_EXEC: begin
          if (cnt == CNT_W'(1)) begin
            state <= ST_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (grant) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: rtl/fu_exec_pool.sv
// Pool of four functional units with round-robin single-retire arbitration.
// Ports: issue_* in, fu_busy/retire_* out, sticky err_issue_busy/err_slot_dup.
module fu_exec_pool
  import fu_pkg::*;
#(
  parameter int LAT_ALU = 1,
  parameter int LAT_LSU = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 6,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       issue_valid,
  input  logic [7:0] issue_instr,
  input  logic [1:0] issue_slot,
  input  logic [1:0] issue_fu_type,
  output logic [3:0] fu_busy,
  output logic       retire_valid,
  output logic [3:0] retire_onehot,
  output logic [1:0] retire_dest,
  output logic [1:0] retire_fu,
  output logic       err_issue_busy,
  output logic       err_slot_dup
);

  logic [3:0] done;
  logic [3:0] start;
  logic [3:0] grant;
  logic [1:0] slot_u [4];
  logic [1:0] dest_u [4];
  logic [1:0] dest_in;
  logic       accept;
  logic       hit_busy;
  logic       dup;
  logic [1:0] rr_ptr;
  logic       gnt_any;
  logic [1:0] gnt_idx;
  logic [1:0] idx;
  logic       unused_fields;

  assign unused_fields = ^{issue_instr[OP_HI:OP_LO],
                           issue_instr[SRC0_HI:SRC0_LO],
                           issue_instr[SRC1_HI:SRC1_LO]};

  assign dest_in  = instr_dest(issue_instr);
  assign hit_busy = fu_busy[issue_fu_type];
  // flush wins over a same-cycle issue
  assign accept   = issue_valid && !flush && !hit_busy;

  assign start[0] = accept && (issue_fu_type == FU_ALU);
  assign start[1] = accept && (issue_fu_type == FU_LSU);
  assign start[2] = accept && (issue_fu_type == FU_MUL);
  assign start[3] = accept && (issue_fu_type == FU_DIV);

  fu_unit #(.LAT(LAT_ALU), .CNT_W(CNT_W)) u_alu (
    .clk(clk), .reset(reset), .flush(flush),
    .start(start[0]), .slot_in(issue_slot),
    .dest_in(dest_in), .grant(grant[0]),
    .busy(fu_busy[0]), .done(done[0]),
    .slot(slot_u[0]), .dest(dest_u[0])
  );

  fu_unit #(.LAT(LAT_LSU), .CNT_W(CNT_W)) u_lsu (
    .clk(clk), .reset(reset), .flush(flush),
    .start(start[1]), .slot_in(issue_slot),
    .dest_in(dest_in), .grant(grant[1]),
    .busy(fu_busy[1]), .done(done[1]),
    .slot(slot_u[1]), .dest(dest_u[1])
  );

  fu_unit #(.LAT(LAT_MUL), .CNT_W(CNT_W)) u_mul (
    .clk(clk), .reset(reset), .flush(flush),
    .start(start[2]), .slot_in(issue_slot),
    .dest_in(dest_in), .grant(grant[2]),
    .busy(fu_busy[2]), .done(done[2]),
    .slot(slot_u[2]), .dest(dest_u[2])
  );

  fu_unit #(.LAT(LAT_DIV), .CNT_W(CNT_W)) u_div (
    .clk(clk), .reset(reset), .flush(flush),
    .start(start[3]), .slot_in(issue_slot),
    .dest_in(dest_in), .grant(grant[3]),
    .busy(fu_busy[3]), .done(done[3]),
    .slot(slot_u[3]), .dest(dest_u[3])
  );

  always_comb begin
    dup = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (fu_busy[k] && slot_u[k] == issue_slot) dup = 1'b1;
    end
  end

  // first DONE unit at or after rr_ptr, wrapping
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_ptr;
    idx     = rr_ptr;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!gnt_any && done[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign grant = (gnt_any && !flush) ? (4'b0001 << gnt_idx) : 4'b0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_valid  <= 1'b0;
      retire_onehot <= 4'b0000;
      retire_dest   <= 2'd0;
      retire_fu     <= 2'd0;
      rr_ptr        <= 2'd0;
    end else if (flush) begin
      retire_valid  <= 1'b0;
      retire_onehot <= 4'b0000;
      retire_dest   <= 2'd0;
      retire_fu     <= 2'd0;
    end else if (gnt_any) begin
      retire_valid  <= 1'b1;
      retire_onehot <= 4'b0001 << slot_u[gnt_idx];
      retire_dest   <= dest_u[gnt_idx];
      retire_fu     <= gnt_idx;
      rr_ptr        <= gnt_idx + 2'd1;
    end else begin
      retire_valid  <= 1'b0;
      retire_onehot <= 4'b0000;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_issue_busy <= 1'b0;
      err_slot_dup   <= 1'b0;
    end else if (issue_valid && !flush) begin
      if (hit_busy) err_issue_busy <= 1'b1;
      if (dup)      err_slot_dup   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fu_exec_pool.sv
// Scoreboard bench for fu_exec_pool: directed issues push expected
// retires; a negedge monitor pops and compares each retire pulse.
module tb_fu_exec_pool;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       issue_valid;
  logic [7:0] issue_instr;
  logic [1:0] issue_slot;
  logic [1:0] issue_fu_type;
  logic [3:0] fu_busy;
  logic       retire_valid;
  logic [3:0] retire_onehot;
  logic [1:0] retire_dest;
  logic [1:0] retire_fu;
  logic       err_issue_busy;
  logic       err_slot_dup;

  typedef struct {
    logic [3:0] oh;
    logic [1:0] d;
    logic [1:0] f;
    int         c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  fu_exec_pool dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_instr(issue_instr),
    .issue_slot(issue_slot), .issue_fu_type(issue_fu_type),
    .fu_busy(fu_busy), .retire_valid(retire_valid),
    .retire_onehot(retire_onehot), .retire_dest(retire_dest),
    .retire_fu(retire_fu), .err_issue_busy(err_issue_busy),
    .err_slot_dup(err_slot_dup)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (retire_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_retire cyc=%0d oh=%b", cyc, retire_onehot);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (retire_onehot !== e.oh || retire_dest !== e.d ||
              retire_fu !== e.f || cyc != e.c) begin
            errors++;
            $display("FAIL retire got oh=%b d=%0d f=%0d cyc=%0d exp oh=%b d=%0d f=%0d cyc=%0d",
                     retire_onehot, retire_dest, retire_fu, cyc,
                     e.oh, e.d, e.f, e.c);
          end
        end
      end else if (retire_onehot !== 4'b0000) begin
        checks++;
        errors++;
        $display("FAIL onehot_idle got %b exp 0000", retire_onehot);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [1:0] fu, input logic [1:0] slot,
                          input logic [7:0] instr, output int e);
    issue_valid   = 1'b1;
    issue_fu_type = fu;
    issue_slot    = slot;
    issue_instr   = instr;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    e = cyc;
  endtask

  task automatic push(input logic [3:0] oh, input logic [1:0] d,
                      input logic [1:0] f, input int c);
    exp_t x;
    x.oh = oh; x.d = d; x.f = f; x.c = c;
    sb.push_back(x);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((fu_busy != 4'b0000 || sb.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL %s_timeout busy=%b pending=%0d", name, fu_busy, sb.size());
    end
    tick();
  endtask

  initial begin
    int e, e2;
    reset = 1'b1; flush = 1'b0; issue_valid = 1'b0;
    issue_instr = 8'h00; issue_slot = 2'd0; issue_fu_type = 2'd0;
    tick(); tick();
    chk("rst_busy", {4'b0, fu_busy}, 8'h00);
    chk("rst_rv", {7'b0, retire_valid}, 8'h00);
    chk("rst_oh", {4'b0, retire_onehot}, 8'h00);
    chk("rst_err", {6'b0, err_issue_busy, err_slot_dup}, 8'h00);
    reset = 1'b0;
    tick();

    // contention: LSU s1 then ALU s2, both DONE together, rr_ptr=0
    do_issue(2'd1, 2'd1, 8'h4E, e);
    do_issue(2'd0, 2'd2, 8'h01, e2);
    push(4'b0100, 2'd1, 2'd0, e + 3);
    push(4'b0010, 2'd2, 2'd1, e + 4);
    wait_idle("contention");

    // rr_ptr now 2: MUL beats ALU when both DONE
    do_issue(2'd2, 2'd0, 8'h83, e);
    tick();
    do_issue(2'd0, 2'd3, 8'h02, e2);
    push(4'b0001, 2'd3, 2'd2, e + 4);
    push(4'b1000, 2'd2, 2'd0, e + 5);
    wait_idle("rr");

    // ALU latency
    do_issue(2'd0, 2'd0, 8'b00011011, e);
    push(4'b0001, 2'd3, 2'd0, e + 2);
    chk("alu_busy0", {4'b0, fu_busy}, 8'h01);
    tick();
    chk("alu_busy1", {4'b0, fu_busy}, 8'h01);
    tick();
    chk("alu_busy2", {4'b0, fu_busy}, 8'h00);
    wait_idle("alu");

    // flush mid-DIV
    do_issue(2'd3, 2'd1, 8'hC5, e);
    tick(); tick();
    chk("fl_busy_pre", {4'b0, fu_busy}, 8'h08);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_busy", {4'b0, fu_busy}, 8'h00);
    chk("fl_rv", {7'b0, retire_valid}, 8'h00);
    repeat (10) tick();
    chk("fl_pending", 8'(sb.size()), 8'h00);
    chk("fl_err", {6'b0, err_issue_busy, err_slot_dup}, 8'h00);

    // busy issue on DIV
    do_issue(2'd3, 2'd3, 8'hC6, e);
    push(4'b1000, 2'd2, 2'd3, e + 7);
    tick();
    do_issue(2'd3, 2'd2, 8'hC1, e2);
    chk("busy_err", {7'b0, err_issue_busy}, 8'h01);
    chk("busy_dup", {7'b0, err_slot_dup}, 8'h00);
    wait_idle("busy");
    chk("busy_sticky", {7'b0, err_issue_busy}, 8'h01);

    // duplicate slot: MUL s1, then ALU s1
    do_issue(2'd2, 2'd1, 8'h8D, e);
    do_issue(2'd0, 2'd1, 8'h00, e2);
    push(4'b0010, 2'd0, 2'd0, e + 3);
    push(4'b0010, 2'd1, 2'd2, e + 4);
    chk("dup_err", {7'b0, err_slot_dup}, 8'h01);
    wait_idle("dup");

    // full pool
    do_issue(2'd0, 2'd0, 8'h01, e);
    push(4'b0001, 2'd1, 2'd0, e + 2);
    do_issue(2'd1, 2'd1, 8'h42, e2);
    push(4'b0010, 2'd2, 2'd1, e + 4);
    do_issue(2'd2, 2'd2, 8'h83, e2);
    push(4'b0100, 2'd3, 2'd2, e + 6);
    do_issue(2'd3, 2'd3, 8'hC0, e2);
    push(4'b1000, 2'd0, 2'd3, e + 10);
    wait_idle("pool");

    // full pool again, async reset while MUL in EXEC
    do_issue(2'd0, 2'd0, 8'h01, e);
    push(4'b0001, 2'd1, 2'd0, e + 2);
    do_issue(2'd1, 2'd1, 8'h42, e2);
    push(4'b0010, 2'd2, 2'd1, e + 4);
    do_issue(2'd2, 2'd2, 8'h83, e2);
    do_issue(2'd3, 2'd3, 8'hC0, e2);
    tick();
    @(negedge clk);
    #1;
    chk("pre_rst_busy", {4'b0, fu_busy}, 8'h0C);
    reset = 1'b1;
    #1;
    chk("ar_busy", {4'b0, fu_busy}, 8'h00);
    chk("ar_rv", {7'b0, retire_valid}, 8'h00);
    chk("ar_oh", {4'b0, retire_onehot}, 8'h00);
    chk("ar_dest_fu", {4'b0, retire_dest, retire_fu}, 8'h00);
    chk("ar_err", {6'b0, err_issue_busy, err_slot_dup}, 8'h00);
    tick(); tick();
    reset = 1'b0;
    repeat (15) tick();
    chk("ar_pending", 8'(sb.size()), 8'h00);
    chk("ar_busy_end", {4'b0, fu_busy}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
